// File: rtl/sblk_act_feeder.sv
// sblk_act_feeder: packs activation word pairs into a beat FIFO and answers row write requests via a credit counter.
// Optional sticky error output feeder_err is built when FTDNN_FEEDER_ERR_EN is defined.
module sblk_act_feeder #(
    parameter int ACTBUF_DATA_LEN = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int CREDIT_LEN      = 4
) (
    input  logic                         clk_l,
    input  logic                         rst,
    input  logic [ACTBUF_DATA_LEN-1:0]   act_in_data,
    input  logic                         act_in_vld,
    input  logic                         act_in_last,
    output logic                         act_in_rdy,
    input  logic                         actbuf_wr_req,
    output logic                         actbuf_wr_vld,
    output logic [2*ACTBUF_DATA_LEN-1:0] actbuf_wr_data,
    output logic                         feeder_empty
`ifdef FTDNN_FEEDER_ERR_EN
    ,output logic                        feeder_err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = 2 * ACTBUF_DATA_LEN;

    typedef enum logic {LO_EMPTY, LO_FULL} state_t;

    state_t                     state_q;
    logic [ACTBUF_DATA_LEN-1:0] lo_q;
    logic [BW-1:0]              mem_q [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic [CREDIT_LEN-1:0]      pend_q, pend_d;
    logic [BW-1:0]              wr_data_q, push_data;
    logic                       wr_vld_q, acc, push, issue, pend_sat;

    assign act_in_rdy     = count_q != CW'(FIFO_DEPTH);
    assign acc            = act_in_vld && act_in_rdy;
    assign push           = acc && (state_q == LO_FULL || act_in_last);
    assign push_data      = state_q == LO_FULL ? {act_in_data, lo_q} : {{ACTBUF_DATA_LEN{1'b0}}, act_in_data};
    assign issue          = pend_q != '0 && count_q != '0;
    assign pend_sat       = &pend_q;
    assign count_d        = count_q + CW'(push) - CW'(issue);
    // A request at saturation is dropped unless an issue frees a credit in the same cycle.
    assign pend_d         = (pend_sat && actbuf_wr_req && !issue) ? pend_q
                          : pend_q + CREDIT_LEN'(actbuf_wr_req) - CREDIT_LEN'(issue);
    assign actbuf_wr_vld  = wr_vld_q;
    assign actbuf_wr_data = wr_data_q;
    assign feeder_empty   = count_q == '0 && state_q == LO_EMPTY;

    always_ff @(posedge clk_l)
        if (push) mem_q[wr_ptr_q] <= push_data;

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q   <= LO_EMPTY;
            lo_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            wr_vld_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            if (acc && state_q == LO_EMPTY && !act_in_last) begin
                lo_q    <= act_in_data;
                state_q <= LO_FULL;
            end else if (acc) begin
                state_q <= LO_EMPTY;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                wr_data_q <= mem_q[rd_ptr_q];
            end
            wr_vld_q <= issue;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

`ifdef FTDNN_FEEDER_ERR_EN
    logic err_q;
    assign feeder_err = err_q;
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if ((actbuf_wr_req && pend_sat) || (act_in_vld && !act_in_rdy && act_in_last)) err_q <= 1'b1;
    end
`endif
endmodule
